// File: rtl/tdm_pkg.sv
// tdm_pkg: slot constants and link-state enumeration shared by the TDM mux/demux pair.
package tdm_pkg;
    localparam logic [1:0] SLOT_A = 2'd0;
    localparam logic [1:0] SLOT_B = 2'd1;
    localparam logic [1:0] SLOT_C = 2'd2;
    localparam logic [1:0] SLOT_D = 2'd3;
    localparam int NUM_SLOTS = 4;
    typedef enum logic {HUNT, LOCKED} state_t;
endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: 2-bit wrapping slot counter with clear, load-to-1 and advance.
module tdm_slot_ctr (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       load1_i,
    input  logic       adv_i,
    output logic [1:0] sel_o
);
    logic [1:0] sel_q, sel_d;
    assign sel_d = clr_i ? 2'd0 : load1_i ? 2'd1 : adv_i ? sel_q + 2'd1 : sel_q;
    always_ff @(posedge clk) begin
        if (rst) sel_q <= 2'd0;
        else sel_q <= sel_d;
    end
    assign sel_o = sel_q;
endmodule

// File: rtl/tdm_demux_4.sv
// tdm_demux_4: 4-slot TDM demultiplexer, frame-aligned on sync, presents a..d per frame.
// Define TDM_DEMUX_SYNC_CHK_EN to check sync in LOCKED and add the sync_err output.
module tdm_demux_4
    import tdm_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    input  logic              sync,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] d,
    output logic              frame_valid,
    output logic [1:0]        sel,
`ifdef TDM_DEMUX_SYNC_CHK_EN
    output logic              sync_err,
`endif
    output logic              locked
);
    state_t state_q, state_d;
    logic [DATA_W-1:0] shadow_q [NUM_SLOTS-1];
    logic [DATA_W-1:0] a_q, b_q, c_q, d_q;
    logic fv_q, hunt_hit, lk, norm, load1, clr, fin, wr_en;
    logic [1:0] wr_idx;
    assign hunt_hit = state_q == HUNT && din_valid && sync;
    assign lk = state_q == LOCKED && din_valid;
`ifdef TDM_DEMUX_SYNC_CHK_EN
    logic resync, drop, sync_err_q;
    assign resync = lk && sync && sel != SLOT_A;
    assign drop = lk && !sync && sel == SLOT_A;
    assign norm = lk && !resync && !drop;
    assign load1 = hunt_hit || resync;
    assign clr = drop;
    assign sync_err = sync_err_q;
`else
    assign norm = lk;
    assign load1 = hunt_hit;
    assign clr = 1'b0;
`endif
    assign fin = norm && sel == SLOT_D;
    // A (re)sync sample always lands in slot A; otherwise the current slot is filled.
    assign wr_en = load1 || (norm && sel != SLOT_D);
    assign wr_idx = load1 ? SLOT_A : sel;
    assign state_d = load1 ? LOCKED : clr ? HUNT : state_q;
    tdm_slot_ctr u_ctr (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .load1_i(load1),
        .adv_i  (norm),
        .sel_o  (sel)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            shadow_q <= '{default: '0};
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            d_q <= '0;
            fv_q <= 1'b0;
`ifdef TDM_DEMUX_SYNC_CHK_EN
            sync_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            fv_q <= fin;
            if (wr_en) shadow_q[wr_idx] <= din;
            if (fin) begin
                a_q <= shadow_q[SLOT_A];
                b_q <= shadow_q[SLOT_B];
                c_q <= shadow_q[SLOT_C];
                d_q <= din;
            end
`ifdef TDM_DEMUX_SYNC_CHK_EN
            sync_err_q <= resync || drop;
`endif
        end
    end
    assign a = a_q;
    assign b = b_q;
    assign c = c_q;
    assign d = d_q;
    assign frame_valid = fv_q;
    assign locked = state_q == LOCKED;
endmodule

// File: tb/tb_tdm_demux_4.sv
// tb_tdm_demux_4: directed self-checking bench for tdm_demux_4 with DATA_W=4.
module tb_tdm_demux_4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din_valid = 1'b0;
    logic sync = 1'b0;
    logic [3:0] din = '0;
    logic [3:0] a, b, c, d;
    logic frame_valid, locked;
    logic [1:0] sel;
`ifdef TDM_DEMUX_SYNC_CHK_EN
    logic sync_err;
`endif
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;
    tdm_demux_4 #(.DATA_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .sync       (sync),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .frame_valid(frame_valid),
        .sel        (sel),
`ifdef TDM_DEMUX_SYNC_CHK_EN
        .sync_err   (sync_err),
`endif
        .locked     (locked)
    );
    task automatic step(input logic v, input logic s, input logic [3:0] x);
        din_valid = v;
        sync = s;
        din = x;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, o, e);
        end
    endtask
    task automatic frame(input string tag, input int ea, input int eb, input int ec, input int ed, input logic efv);
        chk({tag, ".a"}, 32'(a), 32'(ea));
        chk({tag, ".b"}, 32'(b), 32'(eb));
        chk({tag, ".c"}, 32'(c), 32'(ec));
        chk({tag, ".d"}, 32'(d), 32'(ed));
        chk({tag, ".fv"}, 32'(frame_valid), 32'(efv));
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        frame("rst", 0, 0, 0, 0, 1'b0);
        chk("rst.locked", 32'(locked), 0);
        chk("rst.sel", 32'(sel), 0);
        rst = 1'b0;
        step(1, 1, 4'd5);
        chk("basic.locked", 32'(locked), 1);
        chk("basic.sel1", 32'(sel), 1);
        step(1, 0, 4'd9);
        step(1, 0, 4'd12);
        chk("basic.sel3", 32'(sel), 3);
        frame("basic.pre", 0, 0, 0, 0, 1'b0);
        step(1, 0, 4'd3);
        frame("basic", 5, 9, 12, 3, 1'b1);
        chk("basic.sel0", 32'(sel), 0);
        step(0, 0, 4'd0);
        frame("basic.hold", 5, 9, 12, 3, 1'b0);
        step(1, 1, 4'd2);
        step(1, 0, 4'd4);
        step(0, 0, 4'd15);
        step(0, 1, 4'd15);
        chk("gap.sel", 32'(sel), 2);
        frame("gap.idle", 5, 9, 12, 3, 1'b0);
        step(1, 0, 4'd6);
        frame("gap.partial", 5, 9, 12, 3, 1'b0);
        step(1, 0, 4'd8);
        frame("gap", 2, 4, 6, 8, 1'b1);
        step(0, 0, 4'd0);
        chk("gap.single", 32'(frame_valid), 0);
        rst = 1'b1;
        step(0, 0, 4'd0);
        rst = 1'b0;
        step(1, 0, 4'd7);
        step(1, 0, 4'd7);
        chk("hunt.locked0", 32'(locked), 0);
        chk("hunt.sel0", 32'(sel), 0);
        step(1, 1, 4'd1);
        chk("hunt.locked1", 32'(locked), 1);
        step(1, 0, 4'd2);
        step(1, 0, 4'd3);
        step(1, 0, 4'd4);
        frame("hunt", 1, 2, 3, 4, 1'b1);
        step(1, 1, 4'd1);
        step(1, 0, 4'd2);
        step(1, 0, 4'd3);
        rst = 1'b1;
        step(0, 0, 4'd0);
        rst = 1'b0;
        frame("midrst", 0, 0, 0, 0, 1'b0);
        chk("midrst.locked", 32'(locked), 0);
        chk("midrst.sel", 32'(sel), 0);
        step(1, 0, 4'd9);
        chk("midrst.hunt", 32'(locked), 0);
        step(1, 1, 4'd6);
        step(1, 0, 4'd7);
        step(1, 0, 4'd8);
        step(1, 0, 4'd9);
        frame("midrst.frame", 6, 7, 8, 9, 1'b1);
`ifdef TDM_DEMUX_SYNC_CHK_EN
        step(1, 1, 4'd1);
        step(1, 0, 4'd2);
        chk("resync.err0", 32'(sync_err), 0);
        step(1, 1, 4'd11);
        chk("resync.err", 32'(sync_err), 1);
        chk("resync.sel", 32'(sel), 1);
        chk("resync.fv", 32'(frame_valid), 0);
        step(1, 0, 4'd12);
        chk("resync.err_clr", 32'(sync_err), 0);
        step(1, 0, 4'd13);
        step(1, 0, 4'd14);
        frame("resync", 11, 12, 13, 14, 1'b1);
        step(1, 0, 4'd5);
        chk("drop.err", 32'(sync_err), 1);
        chk("drop.locked", 32'(locked), 0);
        chk("drop.sel", 32'(sel), 0);
        frame("drop", 11, 12, 13, 14, 1'b0);
`else
        step(1, 1, 4'd1);
        step(1, 0, 4'd2);
        step(1, 1, 4'd11);
        chk("freerun.sel", 32'(sel), 3);
        step(1, 0, 4'd12);
        frame("freerun", 1, 2, 11, 12, 1'b1);
        step(1, 0, 4'd5);
        chk("freerun.locked", 32'(locked), 1);
        chk("freerun.sel1", 32'(sel), 1);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tdm_demux_4.md
# tdm_demux_4

Receive-side counterpart of the 4:1 channel multiplexer. It accepts one time-division-multiplexed sample stream whose samples belong, in rotation, to channels a, b, c and d. Slot 0 is marked by a frame-sync strobe. The block tracks the slot, collects one full frame and presents all four channels together on registered outputs with a one-cycle frame strobe. It sits at the far end of a serial or shared link, where the transmit side drives the mux select in sequence 0, 1, 2, 3.

## Interface
Parameters:
- DATA_W, default 1: width of each channel sample and of the shared data input.

Ports:
- clk, input, 1: single clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- din_valid, input, 1: din and sync carry a sample this cycle.
- din, input, DATA_W: multiplexed sample. Slot 0 maps to a, 1 to b, 2 to c, 3 to d (same mapping as the mux select).
- sync, input, 1: qualified by din_valid; marks the slot-0 sample of a frame.
- a, b, c, d, output, DATA_W each: last complete frame, registered.
- frame_valid, output, 1: one-cycle pulse when a..d update.
- sel, output, 2: slot index that the next accepted sample will fill.
- locked, output, 1: high in state LOCKED.
- sync_err, output, 1: one-cycle pulse on a framing error. Present only with TDM_DEMUX_SYNC_CHK_EN.

## Operation
- States:
  - HUNT: not aligned.
  - LOCKED: aligned to frame.
- Reset values: state HUNT, sel=0, a=b=c=d=0, frame_valid=0, locked=0, sync_err=0, shadow registers 0.
- A sample is accepted only on a cycle with din_valid=1. When din_valid=0 there is no state, sel or shadow change, and frame_valid=0.
- HUNT:
  - An accepted sample with sync=0 is discarded.
  - An accepted sample with sync=1 is stored in shadow[0]; sel goes to 1 and the state goes to LOCKED.
- LOCKED, sample accepted at sel = 0, 1 or 2: store it in shadow[sel], then sel increments by 1.
- LOCKED, sample accepted at sel=3:
  - a<=shadow[0], b<=shadow[1], c<=shadow[2], d<=din.
  - frame_valid<=1 for exactly one cycle.
  - sel wraps to 0.
- The sync check and all checker behaviour are under Configuration.
- Reset asserted mid-frame: the partial frame is discarded, outputs clear to 0, the state returns to HUNT.
- The a..d outputs hold their value between frames. They never show a partially updated frame.

## Timing
- Latency: the slot-3 sample accepted in cycle N gives a..d updated and frame_valid=1 in cycle N+1 (registered outputs).
- Minimum frame period is 4 cycles with din_valid held high, so frame_valid is at most one pulse per 4 cycles.
- sel and locked are registered and reflect the state after the previous edge.
- sync_err, when present, pulses in the cycle after the offending sample.

## Configuration
- Macro TDM_DEMUX_SYNC_CHK_EN.
- Defined: sync is checked on every accepted sample in LOCKED, and the sync_err port exists.
  - sync=1 at sel≠0: resync. The partial frame is dropped, the sample is stored in shadow[0], sel=1, sync_err pulses, and there is no frame_valid.
  - sync=0 at sel=0: the sample is dropped, sync_err pulses, and the state returns to HUNT with sel=0.
- Undefined: sync is consulted only in HUNT. LOCKED free-runs on sel, the sync_err port is absent, and no error logic is built.

## Structure
- Shared package tdm_pkg holds:
  - slot constants SLOT_A..SLOT_D = 0..3;
  - NUM_SLOTS = 4;
  - the state enumeration (HUNT, LOCKED).
- The transmit-side sequencer also imports tdm_pkg.
- One sub-module, tdm_slot_ctr: a 2-bit wrapping counter with inputs clear, load-to-1 and advance, and output sel.

## Test plan
- Reset: hold rst 2 cycles, then release. All outputs 0, locked=0, sel=0.
- Basic frame, DATA_W=4: feed din 5,9,12,3 on consecutive valid cycles with sync on the first. The cycle after the 4th sample gives a=5 b=9 c=12 d=3 with frame_valid=1 for one cycle, and sel=0.
- Gaps: the same frame with din_valid=0 for 2 cycles between samples 2 and 3. The result is the same values and a single frame_valid, with no change to a..d before completion.
- HUNT discard: feed 7,7 with sync=0, then frame 1,2,3,4 with sync on 1. Output a..d = 1,2,3,4; locked rises after the sample of value 1.
- Resync (macro on): sync after 2 samples of a frame. sync_err pulses, there is no frame_valid, and the next 4 samples starting at the sync sample form the output frame.
- Mid-frame reset: assert rst after 3 samples of frame 1,2,3. Outputs stay 0 and state is HUNT. The following synced frame 6,7,8,9 appears correctly.
